// File: rtl/mbank_dpram_pipelined_pkg.sv
// mbank_pkg: geometry helpers, arbiter winner encoding and write-pipeline entry type
package mbank_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_BANKS = 4;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;
  function automatic int bank_w(input int num_banks);
    return $clog2(num_banks);
  endfunction
  function automatic int row_w(input int addr_w, input int num_banks);
    return addr_w - $clog2(num_banks);
  endfunction
  localparam int DEF_BW = bank_w(DEF_NUM_BANKS);
  localparam int DEF_RW = row_w(DEF_ADDR_W, DEF_NUM_BANKS);
  typedef struct packed {
    logic                  v;
    logic [DEF_BW-1:0]     bank;
    logic [DEF_RW-1:0]     row;
    logic [DEF_DATA_W-1:0] data;
  } wr_entry_t;
endpackage

// File: rtl/mbank_dpram_pipelined_bank.sv
// mbank_bank_1r1w: one bank, 1 read + 1 write per cycle, read-before-write, registered read
module mbank_bank_1r1w #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 3
) (
  input  logic              clk,
  input  logic              re_i,
  input  logic [ROW_W-1:0]  raddr_i,
  input  logic              we_i,
  input  logic [ROW_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [2**ROW_W];
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/mbank_dpram_pipelined.sv
// mbank_dpram_pipelined: dual-port interleaved banked RAM; MBANK_FWD_EN enables write-to-read forwarding
module mbank_dpram_pipelined
  import mbank_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int NUM_BANKS     = DEF_NUM_BANKS,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic [15:0]       conflict_cnt
);
  localparam int BW = bank_w(NUM_BANKS);
  localparam int RW = row_w(ADDR_W, NUM_BANKS);
  localparam int RL = READ_LATENCY;
  localparam int WL = WRITE_LATENCY;
  typedef struct packed {
    logic              v;
    logic [BW-1:0]     bank;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] data;
  } wr_t;
  logic [1:0] valid, we, ready, acc, rvalid;
  logic [ADDR_W-1:0] addr [2];
  logic [BW-1:0] bk [2];
  logic [RW-1:0] rw [2];
  logic [DATA_W-1:0] wdata [2], rdata [2], bank_rd [NUM_BANKS];
  wr_t wp_q [2][WL];
  logic conflict;
  port_e rr_q;
  logic [15:0] cnt_q;
  assign valid = {b_valid, a_valid};
  assign we = {b_we, a_we};
  assign addr[0] = a_addr;
  assign addr[1] = b_addr;
  assign wdata[0] = a_wdata;
  assign wdata[1] = b_wdata;
  assign bk[0] = a_addr[BW-1:0];
  assign bk[1] = b_addr[BW-1:0];
  assign rw[0] = a_addr[ADDR_W-1:BW];
  assign rw[1] = b_addr[ADDR_W-1:BW];
  assign conflict = &valid && bk[0] == bk[1];
  assign ready[0] = !rst && !(conflict && rr_q == PORT_B);
  assign ready[1] = !rst && !(conflict && rr_q == PORT_A);
  assign acc = valid & ready;
  assign {b_ready, a_ready} = ready;
  assign {b_rvalid, a_rvalid} = rvalid;
  assign a_rdata = rdata[0];
  assign b_rdata = rdata[1];
  assign conflict_cnt = cnt_q;
  always_ff @(posedge clk)
    if (rst) begin
      rr_q <= PORT_A;
      cnt_q <= '0;
    end else if (conflict) begin
      rr_q <= (rr_q == PORT_A) ? PORT_B : PORT_A;
      cnt_q <= cnt_q + 16'(!(&cnt_q));
    end
  // stage 0 holds writes accepted at the previous edge; stage WL-1 commits
  always_ff @(posedge clk)
    for (int p = 0; p < 2; p++) begin
      wp_q[p][0] <= '{v: acc[p] && we[p], bank: bk[p], row: rw[p], data: wdata[p]};
      for (int s = 1; s < WL; s++) wp_q[p][s] <= wp_q[p][s-1];
      if (rst) for (int s = 0; s < WL; s++) wp_q[p][s].v <= 1'b0;
    end
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [1:0] rs, ws;
    assign rs = acc & ~we & {bk[1] == BW'(b), bk[0] == BW'(b)};
    assign ws = {2{!rst}} & {wp_q[1][WL-1].v && wp_q[1][WL-1].bank == BW'(b),
                             wp_q[0][WL-1].v && wp_q[0][WL-1].bank == BW'(b)};
    mbank_bank_1r1w #(.DATA_W(DATA_W), .ROW_W(RW)) u_bank (
      .clk(clk),
      .re_i(|rs),
      .raddr_i(rs[1] ? rw[1] : rw[0]),
      .we_i(|ws),
      .waddr_i(ws[1] ? wp_q[1][WL-1].row : wp_q[0][WL-1].row),
      .wdata_i(ws[1] ? wp_q[1][WL-1].data : wp_q[0][WL-1].data),
      .rdata_o(bank_rd[b])
    );
  end
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [RL-1:0] v_q;
    logic [BW-1:0] bank_q;
    logic fwd_q, hit, rd_acc;
    logic [DATA_W-1:0] fwd_d_q, hit_d, d1, pd, hold_q;
    assign rd_acc = acc[p] && !we[p];
`ifdef MBANK_FWD_EN
    // oldest stage first so the youngest matching write wins
    always_comb begin
      hit = 1'b0;
      hit_d = '0;
      for (int s = WL-1; s >= 0; s--)
        for (int q = 0; q < 2; q++)
          if (wp_q[q][s].v && {wp_q[q][s].row, wp_q[q][s].bank} == addr[p]) begin
            hit = 1'b1;
            hit_d = wp_q[q][s].data;
          end
    end
`else
    assign hit = 1'b0;
    assign hit_d = '0;
`endif
    always_ff @(posedge clk) begin
      v_q <= rst ? '0 : RL'({v_q, rd_acc});
      if (rd_acc) begin
        bank_q <= bk[p];
        fwd_q <= hit;
        fwd_d_q <= hit_d;
      end
      if (rst) hold_q <= '0;
      else if (v_q[RL-1]) hold_q <= pd;
    end
    assign d1 = fwd_q ? fwd_d_q : bank_rd[bank_q];
    if (RL == 1) begin : g_rl1
      assign pd = d1;
    end else begin : g_rln
      logic [DATA_W-1:0] dq_q [RL-1];
      always_ff @(posedge clk) begin
        dq_q[0] <= d1;
        for (int k = 1; k < RL-1; k++) dq_q[k] <= dq_q[k-1];
      end
      assign pd = dq_q[RL-2];
    end
    assign rvalid[p] = v_q[RL-1];
    assign rdata[p] = v_q[RL-1] ? pd : hold_q;
  end
endmodule

// File: doc/mbank_dpram_pipelined.md
Name: mbank_dpram_pipelined

Overview:
Dual-port, multi-bank, word-interleaved RAM with configurable read and write latency. It is the parametrised successor of the single-port multi-bank latency RAM and sits behind the AXI dual-port RAM front end. Each port has a valid/ready request handshake and a read-valid strobe. When both ports target the same bank in one cycle, a round-robin arbiter serialises them.

Parameters:
DATA_W, 8, data word width
ADDR_W, 5, word address width; total depth 2**ADDR_W
NUM_BANKS, 4, bank count; power of two, at least 2, at most 2**ADDR_W
READ_LATENCY, 2, cycles from read acceptance to rvalid; at least 1
WRITE_LATENCY, 2, cycles from write acceptance to array commit; at least 1

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
a_valid  in  1  port A request valid
a_ready  out  1  port A request accepted this cycle when high with a_valid
a_we  in  1  port A: 1 = write, 0 = read
a_addr  in  ADDR_W  port A word address
a_wdata  in  DATA_W  port A write data
a_rdata  out  DATA_W  port A read data
a_rvalid  out  1  port A read data valid, 1-cycle pulse
b_valid, b_ready, b_we, b_addr, b_wdata, b_rdata, b_rvalid  same as port A, for port B
conflict_cnt  out  16  saturating count of bank-conflict cycles

Behaviour:
- Address mapping: bank = addr[BW-1:0] and row = addr[ADDR_W-1:BW], where BW = log2(NUM_BANKS). Each bank holds 2**ADDR_W/NUM_BANKS rows, with 1 read and 1 write per cycle.
- Acceptance: a request is accepted at a rising edge when valid && ready.
- Ready generation: ready is combinational and is low while rst = 1. It is otherwise high, except for the losing port in a conflict.
- Conflict: both ports valid and bank(a_addr) == bank(b_addr), regardless of we.
  - Winner is the port selected by the rr bit (0 = A, 1 = B); rr toggles after every conflict cycle.
  - The loser holds its request stable until accepted.
- Consequence: no two accepts in one cycle ever share a bank. Writes commit WRITE_LATENCY cycles later and pipelines are equal-length, so simultaneous commits never share a bank.
- Write: accepted at edge t, the write commits at edge t+WRITE_LATENCY.
- Read:
  - Accepted at edge t, the array is sampled at edge t.
  - A commit on the same edge is not visible (read-before-write).
  - Data is presented on rdata with rvalid = 1 during the cycle after edge t+READ_LATENCY-1, i.e. exactly READ_LATENCY cycles after acceptance.
  - Back-to-back reads give one rvalid per accepted read, in order.
- Output holding: rdata holds its last value while rvalid = 0.
- conflict_cnt increments on each conflict cycle and saturates at 0xFFFF.
- Reset values: a_rdata/b_rdata = 0, a_rvalid/b_rvalid = 0, rr = 0, conflict_cnt = 0. Read and write pipelines are cleared.
- Array contents are not reset.
- Reset mid-operation: in-flight writes are discarded and never commit. In-flight reads are dropped with no rvalid.
- Address wrap: none. Every ADDR_W value is legal.

Optional Feature:
MBANK_FWD_EN
- Defined: write-to-read forwarding. A read accepted at edge t returns the youngest write to the same address accepted at any edge before t that has not yet committed (either port; same-age ties cannot occur). If no such write exists, the array value is returned.
- Undefined: no forwarding. Reads return array contents as specified above, i.e. stale data within the write window.

Decomposition:
- Package mbank_pkg: bank-index and row width helper functions (clog2-based), the arbiter-winner enum (PORT_A, PORT_B), and a packed write-pipeline entry struct (valid, bank, row, data) parametrised via localparams.
- One natural sub-module, mbank_bank_1r1w: a single bank with 1 read and 1 write port, read-before-write, registered read. It is instantiated NUM_BANKS times.

Test Plan:
1. Reset: hold rst 3 cycles with a_valid = b_valid = 1 -> a_ready = b_ready = 0, rvalid = 0, rdata = 0, conflict_cnt = 0.
2. Fill and read back: port A writes addr i = data i for i = 0..31, then reads 0..31 back-to-back -> a_rvalid each cycle starting 2 cycles after the first read, a_rdata = 0..31 in order.
3. Parallel writes: same cycle A writes 5 = 0xAA, B writes 6 = 0xBB (banks 1, 2) -> both ready. Later reads return 0xAA and 0xBB; conflict_cnt unchanged.
4. Conflict: A and B both read, addrs 4 and 8 (bank 0), held valid -> cycle 1 A accepted, b_ready = 0; cycle 2 B accepted; conflict_cnt = 1. Repeat -> B wins first, conflict_cnt = 2.
5. Read-after-write: addr 3 holds 0x03; A writes 3 = 0x5A at edge t; B reads 3 at edge t+1 -> b_rdata = 0x03 without MBANK_FWD_EN, 0x5A with it. A read at t+3 returns 0x5A in both builds.
6. Reset mid-op: A writes 7 = 0xEE, rst asserted the next cycle for 1 cycle; then read 7 -> returns the prior value 7; no spurious rvalid during or after reset.
